debug_unit: RTL and testbench



---
 rtl/debug_pkg.sv | 28 ++
 rtl/debug_word_sender.sv | 76 +++++++
 rtl/debug_unit.sv | 217 +++++++++++++++++++++
 tb/tb_debug_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared constants for the UART-driven debug controller:
//   - state_e   : controller state codes (also reported on o_debug_state)
//   - CMD_*     : host command bytes
//   - HALT_WORD : instruction word that terminates a program load
// -----------------------------------------------------------------------------
package debug_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_LOAD = 4'd1,
    ST_MODE = 4'd2,
    ST_RUN  = 4'd3,
    ST_STEP = 4'd4,
    ST_SEND = 4'd5
  } state_e;

  localparam logic [7:0] CMD_LOAD = 8'h64;  // 'd'
  localparam logic [7:0] CMD_CONT = 8'h63;  // 'c'
  localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
  localparam logic [7:0] CMD_NEXT = 8'h6E;  // 'n'
  localparam logic [7:0] CMD_STOP = 8'h70;  // 'p'
  localparam logic [7:0] CMD_EXIT = 8'h65;  // 'e'

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/debug_word_sender.sv
// -----------------------------------------------------------------------------
// debug_word_sender
// Serializes one SIZE_INSTRUC-bit word into SIZE_TRAMA-bit bytes, MSB first,
// handshaking with a UART transmitter.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_start        : one-cycle request; i_word is captured in that cycle
//   i_word         : word to transmit
//   i_tx_done      : one-cycle pulse from the transmitter when a byte is out
//   o_tx_start     : one-cycle start pulse per byte
//   o_tx_data      : byte being transmitted (held until the next byte)
//   o_done         : one-cycle pulse after the last byte's tx_done
// -----------------------------------------------------------------------------
module debug_word_sender
  import debug_pkg::*;
#(
  parameter int SIZE_TRAMA   = 8,
  parameter int SIZE_INSTRUC = 32
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [SIZE_INSTRUC-1:0] i_word,
  input  logic                    i_tx_done,
  output logic                    o_tx_start,
  output logic [SIZE_TRAMA-1:0]   o_tx_data,
  output logic                    o_done
);

  localparam int NBYTES = SIZE_INSTRUC / SIZE_TRAMA;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);

  logic [SIZE_INSTRUC-1:0] shift_q;
  logic [CW-1:0]           cnt_q;
  logic                    busy_q;
  logic                    tx_start_q;
  logic [SIZE_TRAMA-1:0]   tx_data_q;
  logic                    done_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      if (i_start && !busy_q) begin
        // First byte goes out straight from the input; the rest are shifted up.
        busy_q     <= 1'b1;
        cnt_q      <= '0;
        tx_start_q <= 1'b1;
        tx_data_q  <= i_word[SIZE_INSTRUC-1 -: SIZE_TRAMA];
        shift_q    <= {i_word[SIZE_INSTRUC-SIZE_TRAMA-1:0], {SIZE_TRAMA{1'b0}}};
      end else if (busy_q && i_tx_done) begin
        if (cnt_q == CNT_LAST) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt_q      <= cnt_q + 1'b1;
          tx_start_q <= 1'b1;
          tx_data_q  <= shift_q[SIZE_INSTRUC-1 -: SIZE_TRAMA];
          shift_q    <= {shift_q[SIZE_INSTRUC-SIZE_TRAMA-1:0], {SIZE_TRAMA{1'b0}}};
        end
      end
    end
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_done     = done_q;

endmodule

// File: rtl/debug_unit.sv
// -----------------------------------------------------------------------------
// debug_unit
// Debug controller between a UART and the MIPS core. Loads the program into
// instruction memory (four bytes per word, MSB first), gates the core clock
// enable in continuous or single-step mode and reports the core cycle count
// back over the UART after each run or step.
//
// Ports:
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_uart_rx_flag_ready    : RX byte valid (level, consumed on its rising edge)
//   i_uart_rx_data          : received byte
//   i_uart_tx_done          : TX finished a byte (one-cycle pulse)
//   i_clk_wiz_count         : core cycle counter to report
//   o_uart_rx_reset         : one-cycle acknowledge per consumed RX byte
//   o_ctl_clk_wiz           : core clock enable
//   o_select_mem_ins_dir    : instruction memory word address
//   o_dato_mem_ins          : assembled instruction word
//   o_flag_instr_write      : instruction memory write strobe
//   o_uart_tx_start         : TX start pulse
//   o_uart_tx_data          : TX byte
//   o_debug_state           : state code
//
// Build option: define DEBUG_STATE_EN to drive o_debug_state with the state
// code; otherwise o_debug_state is tied to 4'h0.
// -----------------------------------------------------------------------------
module debug_unit
  import debug_pkg::*;
#(
  parameter  int SIZE_TRAMA       = 8,
  parameter  int SIZE_INSTRUC     = 32,
  parameter  int SIZE_MEM_INSTRUC = 256,
  localparam int MEM_INSTR_SIZE   = $clog2(SIZE_MEM_INSTRUC)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_uart_rx_flag_ready,
  input  logic [SIZE_TRAMA-1:0]     i_uart_rx_data,
  input  logic                      i_uart_tx_done,
  input  logic [SIZE_INSTRUC-1:0]   i_clk_wiz_count,
  output logic                      o_uart_rx_reset,
  output logic                      o_ctl_clk_wiz,
  output logic [MEM_INSTR_SIZE-1:0] o_select_mem_ins_dir,
  output logic [SIZE_INSTRUC-1:0]   o_dato_mem_ins,
  output logic                      o_flag_instr_write,
  output logic                      o_uart_tx_start,
  output logic [SIZE_TRAMA-1:0]     o_uart_tx_data,
  output logic [3:0]                o_debug_state
);

  localparam int NBYTES = SIZE_INSTRUC / SIZE_TRAMA;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCW-1:0]            BYTE_LAST = BCW'(NBYTES - 1);
  localparam logic [MEM_INSTR_SIZE-1:0] ADDR_LAST = MEM_INSTR_SIZE'(SIZE_MEM_INSTRUC - 1);

  state_e                    state_q;
  logic                      rx_prev_q;
  logic                      rx_ack_q;
  logic                      ctl_q;
  logic                      step_pulse_q;
  logic                      origin_step_q;
  logic                      wr_q;
  logic                      send_start_q;
  logic [MEM_INSTR_SIZE-1:0] addr_q;
  logic [BCW-1:0]            byte_cnt_q;
  logic [SIZE_INSTRUC-1:0]   dato_q;
  logic [SIZE_TRAMA-1:0]     byte_q [NBYTES-1];

  logic                      rx_edge;
  logic                      send_done;
  logic [SIZE_INSTRUC-1:0]   word_asm;

  // A held-high ready level is one byte: only the 0->1 transition counts.
  assign rx_edge = i_uart_rx_flag_ready & ~rx_prev_q;

  // Word completed by the byte currently on the RX bus: earlier bytes from
  // byte_q fill the upper lanes, the incoming byte is the least significant.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES - 1; gi++) begin : g_asm
      assign word_asm[SIZE_INSTRUC-1-gi*SIZE_TRAMA -: SIZE_TRAMA] = byte_q[gi];
    end
  endgenerate
  assign word_asm[SIZE_TRAMA-1:0] = i_uart_rx_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      rx_prev_q     <= 1'b0;
      rx_ack_q      <= 1'b0;
      ctl_q         <= 1'b0;
      step_pulse_q  <= 1'b0;
      origin_step_q <= 1'b0;
      wr_q          <= 1'b0;
      send_start_q  <= 1'b0;
      addr_q        <= '0;
      byte_cnt_q    <= '0;
      dato_q        <= '0;
      for (int i = 0; i < NBYTES - 1; i++) byte_q[i] <= '0;
    end else begin
      rx_prev_q    <= i_uart_rx_flag_ready;
      rx_ack_q     <= rx_edge;  // every consumed byte is acknowledged, in any state
      wr_q         <= 1'b0;
      send_start_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (rx_edge && i_uart_rx_data == CMD_LOAD) begin
            state_q    <= ST_LOAD;
            addr_q     <= '0;
            byte_cnt_q <= '0;
          end
        end

        ST_LOAD: begin
          if (rx_edge) begin
            if (byte_cnt_q == BYTE_LAST) begin
              wr_q       <= 1'b1;
              dato_q     <= word_asm;
              byte_cnt_q <= '0;
            end else begin
              byte_q[byte_cnt_q] <= i_uart_rx_data;
              byte_cnt_q         <= byte_cnt_q + 1'b1;
            end
          end
          // Address advances only after the strobe cycle so the write sees it.
          if (wr_q) begin
            if (dato_q == SIZE_INSTRUC'(HALT_WORD) || addr_q == ADDR_LAST) begin
              state_q    <= ST_MODE;
              addr_q     <= '0;
              byte_cnt_q <= '0;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end

        ST_MODE: begin
          if (rx_edge) begin
            if (i_uart_rx_data == CMD_CONT) begin
              state_q <= ST_RUN;
              ctl_q   <= 1'b1;
            end else if (i_uart_rx_data == CMD_STEP) begin
              state_q <= ST_STEP;
            end else if (i_uart_rx_data == CMD_LOAD) begin
              state_q    <= ST_LOAD;
              addr_q     <= '0;
              byte_cnt_q <= '0;
            end
          end
        end

        ST_RUN: begin
          if (rx_edge && i_uart_rx_data == CMD_STOP) begin
            state_q       <= ST_SEND;
            ctl_q         <= 1'b0;
            send_start_q  <= 1'b1;
            origin_step_q <= 1'b0;
          end
        end

        ST_STEP: begin
          // The single enable cycle is spent still in STEP, then SEND follows.
          if (step_pulse_q) begin
            step_pulse_q  <= 1'b0;
            ctl_q         <= 1'b0;
            state_q       <= ST_SEND;
            send_start_q  <= 1'b1;
            origin_step_q <= 1'b1;
          end else if (rx_edge) begin
            if (i_uart_rx_data == CMD_NEXT) begin
              ctl_q        <= 1'b1;
              step_pulse_q <= 1'b1;
            end else if (i_uart_rx_data == CMD_EXIT) begin
              state_q <= ST_MODE;
            end
          end
        end

        ST_SEND: begin
          if (send_done) begin
            state_q <= origin_step_q ? ST_STEP : ST_MODE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The count is captured by the sender in the first SEND cycle.
  debug_word_sender #(
    .SIZE_TRAMA  (SIZE_TRAMA),
    .SIZE_INSTRUC(SIZE_INSTRUC)
  ) u_sender (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (send_start_q),
    .i_word    (i_clk_wiz_count),
    .i_tx_done (i_uart_tx_done),
    .o_tx_start(o_uart_tx_start),
    .o_tx_data (o_uart_tx_data),
    .o_done    (send_done)
  );

  assign o_uart_rx_reset      = rx_ack_q;
  assign o_ctl_clk_wiz        = ctl_q;
  assign o_select_mem_ins_dir = addr_q;
  assign o_dato_mem_ins       = dato_q;
  assign o_flag_instr_write   = wr_q;

`ifdef DEBUG_STATE_EN
  assign o_debug_state = state_q;
`else
  assign o_debug_state = 4'h0;
`endif

endmodule

// File: tb/tb_debug_unit.sv
// -----------------------------------------------------------------------------
// tb_debug_unit
// Randomized scoreboard bench for debug_unit. Stimulus pushes expected memory
// writes and expected TX bytes into queues; monitor processes pop and compare
// whenever the DUT strobes a write or starts a TX byte. A responder process
// plays the UART transmitter, answering each tx_start with a delayed tx_done.
// -----------------------------------------------------------------------------
module tb_debug_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        tx_done;
  logic [31:0] wiz_count;
  logic        rx_ack;
  logic        ctl;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_wr;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [3:0]  dbg_state;

  always #5 clk = ~clk;

  debug_unit dut (
    .i_clk               (clk),
    .i_reset             (rst),
    .i_uart_rx_flag_ready(rx_ready),
    .i_uart_rx_data      (rx_data),
    .i_uart_tx_done      (tx_done),
    .i_clk_wiz_count     (wiz_count),
    .o_uart_rx_reset     (rx_ack),
    .o_ctl_clk_wiz       (ctl),
    .o_select_mem_ins_dir(mem_addr),
    .o_dato_mem_ins      (mem_data),
    .o_flag_instr_write  (mem_wr),
    .o_uart_tx_start     (tx_start),
    .o_uart_tx_data      (tx_data),
    .o_debug_state       (dbg_state)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];

  int tests_run    = 0;
  int tests_failed = 0;
  int ack_count    = 0;
  int ctl_count    = 0;
  int wr_count     = 0;
  int bytes_sent   = 0;
  logic prev_wr    = 1'b0;
  logic prev_txs   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // State codes are only visible when the DUT is built with DEBUG_STATE_EN.
  function automatic logic [3:0] exp_state(input logic [3:0] s);
`ifdef DEBUG_STATE_EN
    return s;
`else
    return 4'h0;
`endif
  endfunction

  // Monitor: scoreboard for writes and TX bytes, plus pulse counters.
  always @(negedge clk) begin
    if (rx_ack) ack_count++;
    if (ctl) ctl_count++;
    if (mem_wr) begin
      wr_count++;
      check("wr_strobe_one_cycle", {31'd0, prev_wr}, 32'd0);
      if (exp_wr.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_write: addr 0x%02h data 0x%08h, expected no write", mem_addr, mem_data);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
        check("wr_data", mem_data, e.data);
      end
    end
    if (tx_start) begin
      check("tx_start_one_cycle", {31'd0, prev_txs}, 32'd0);
      if (exp_tx.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_tx: byte 0x%02h, expected no transmission", tx_data);
      end else begin
        logic [7:0] eb;
        eb = exp_tx.pop_front();
        check("tx_byte", {24'd0, tx_data}, {24'd0, eb});
      end
    end
    prev_wr  = mem_wr;
    prev_txs = tx_start;
  end

  // UART transmitter model: each start is answered by a delayed done pulse.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !rst) begin
        repeat ($urandom_range(2, 6)) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte_hold(input logic [7:0] b, input int hold);
    rx_data  = b;
    rx_ready = 1'b1;
    tick(hold);
    rx_ready = 1'b0;
    tick($urandom_range(1, 3));
    bytes_sent++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_byte_hold(b, $urandom_range(1, 3));
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
  endtask

  task automatic load_word(input logic [7:0] addr, input logic [31:0] w);
    wr_t e;
    e.addr = addr;
    e.data = w;
    exp_wr.push_back(e);
    send_word(w);
  endtask

  // The host expects the count as four bytes, most significant first.
  task automatic expect_count(input logic [31:0] c);
    for (int k = 3; k >= 0; k--) exp_tx.push_back(8'((c >> (8 * k)) & 32'hFF));
  endtask

  task automatic wait_tx_drain(input string name);
    int n = 0;
    while (exp_tx.size() != 0 && n < 2000) begin
      tick(1);
      n++;
    end
    check(name, exp_tx.size(), 0);
    tick(12);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == 32'hFFFF_FFFF) w = 32'h1234_5678;
    return w;
  endfunction

  initial begin
    logic [31:0] cnt;
    logic [31:0] words [3];
    int c0;
    int w0;

    rst       = 1'b1;
    rx_ready  = 1'b0;
    rx_data   = 8'h00;
    wiz_count = 32'd0;
    tick(3);
    check("rst_rx_ack",   {31'd0, rx_ack}, 0);
    check("rst_ctl",      {31'd0, ctl}, 0);
    check("rst_addr",     {24'd0, mem_addr}, 0);
    check("rst_data",     mem_data, 0);
    check("rst_wr",       {31'd0, mem_wr}, 0);
    check("rst_tx_start", {31'd0, tx_start}, 0);
    check("rst_tx_data",  {24'd0, tx_data}, 0);
    check("rst_state",    {28'd0, dbg_state}, 0);
    rst = 1'b0;
    tick(2);

    // 'd' held high for 55 cycles is a single byte.
    send_byte_hold(8'h64, 55);
    tick(2);
    check("held_d_one_ack", ack_count, 1);
    check("state_load", {28'd0, dbg_state}, {28'd0, exp_state(4'd1)});

    words[0] = 32'h0000_0000;
    words[1] = 32'h0023_0020;
    words[2] = 32'h0002_0822;
    for (int i = 0; i < 3; i++) load_word(8'(i), words[i]);
    for (int i = 3; i < 7; i++) load_word(8'(i), rand_word());
    load_word(8'd7, 32'hFFFF_FFFF);
    tick(4);
    check("halt_writes_drained", exp_wr.size(), 0);
    check("halt_state_mode", {28'd0, dbg_state}, {28'd0, exp_state(4'd2)});
    check("halt_addr_zero", {24'd0, mem_addr}, 0);
    check("load_ack_count", ack_count, bytes_sent);

    // Single step with count 5, then a random-count step with an RX byte
    // arriving during SEND (must be ignored), then a third step.
    send_byte(8'h73);
    c0 = ctl_count;
    wiz_count = 32'h0000_0005;
    expect_count(wiz_count);
    send_byte(8'h6E);
    wait_tx_drain("step1_tx_drained");
    check("step1_ctl_cycles", ctl_count - c0, 1);
    check("step1_state_step", {28'd0, dbg_state}, {28'd0, exp_state(4'd4)});

    c0 = ctl_count;
    wiz_count = $urandom;
    expect_count(wiz_count);
    send_byte(8'h6E);
    send_byte(8'h65);
    wait_tx_drain("step2_tx_drained");
    check("step2_ctl_cycles", ctl_count - c0, 1);

    c0 = ctl_count;
    wiz_count = $urandom;
    expect_count(wiz_count);
    send_byte(8'h6E);
    wait_tx_drain("step3_tx_drained");
    check("step3_ctl_cycles", ctl_count - c0, 1);
    check("step_ack_count", ack_count, bytes_sent);
    send_byte(8'h65);
    tick(2);
    check("exit_state_mode", {28'd0, dbg_state}, {28'd0, exp_state(4'd2)});

    // Continuous run.
    send_byte(8'h63);
    for (int i = 0; i < 10; i++) begin
      check("run_ctl_high", {31'd0, ctl}, 1);
      tick(1);
    end
    wiz_count = $urandom;
    expect_count(wiz_count);
    send_byte(8'h70);
    check("stop_ctl_low", {31'd0, ctl}, 0);
    c0 = ctl_count;
    send_byte(8'h63);
    wait_tx_drain("run_tx_drained");
    check("run_state_mode", {28'd0, dbg_state}, {28'd0, exp_state(4'd2)});
    check("send_ignores_c", ctl_count - c0, 0);
    check("run_ack_count", ack_count, bytes_sent);

    // Fill the whole memory: the last address ends the load without HALT.
    send_byte(8'h64);
    for (int a = 0; a < 256; a++) load_word(8'(a), rand_word());
    tick(4);
    check("full_writes_drained", exp_wr.size(), 0);
    check("full_state_mode", {28'd0, dbg_state}, {28'd0, exp_state(4'd2)});
    check("full_addr_zero", {24'd0, mem_addr}, 0);
    w0 = wr_count;
    send_word(32'h0000_0000);
    tick(3);
    check("no_write_after_full", wr_count - w0, 0);

    // Reset in the middle of a word: nothing is written.
    send_byte(8'h64);
    w0 = wr_count;
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("midrst_state_idle", {28'd0, dbg_state}, 0);
    check("midrst_addr_zero", {24'd0, mem_addr}, 0);
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    tick(3);
    check("midrst_no_write", wr_count - w0, 0);
    check("midrst_ctl_low", {31'd0, ctl}, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
